// File: rtl/modn_counter.sv
// Programmable-modulus up/down counter with terminal count and wrap pulse.
// Ports: i_clock, i_reset (sync, active-high), i_load/i_count_in parallel load,
//        i_mode (1=up), i_enable step, i_mod_load/i_mod_in modulus write;
//        o_count_out, o_modulus, o_tc (comb), o_wrap, o_load_err (1-cycle pulses).
module modn_counter #(
    parameter int WIDTH       = 4,
    parameter int MOD_DEFAULT = 14
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_mode,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_count_in,
    input  logic             i_mod_load,
    input  logic [WIDTH:0]   i_mod_in,
    output logic [WIDTH-1:0] o_count_out,
    output logic [WIDTH:0]   o_modulus,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_load_err
);

    localparam logic [WIDTH:0] MOD_MAX = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] MOD_RST = (WIDTH+1)'(MOD_DEFAULT);
    localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] TWO     = (WIDTH+1)'(2);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   r_mod;
    logic             r_wrap;
    logic             r_err;

    logic             w_mod_ok;
    logic [WIDTH:0]   w_mod_eff;
    logic [WIDTH:0]   w_last_eff;
    logic [WIDTH:0]   w_last;
    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_in_ext;
    logic             w_in_ok;
    logic             w_shrink;
    logic [WIDTH-1:0] w_next_cnt;
    logic             w_next_wrap;
    logic             w_next_err;

    // Compare in WIDTH+1 bits so a modulus of 2**WIDTH is representable.
    assign w_cnt_ext  = {1'b0, r_count};
    assign w_in_ext   = {1'b0, i_count_in};
    assign w_mod_ok   = i_mod_load && (i_mod_in >= TWO) && (i_mod_in <= MOD_MAX);
    // Loads and range checks on this edge see the newly accepted modulus.
    assign w_mod_eff  = w_mod_ok ? i_mod_in : r_mod;
    assign w_last_eff = w_mod_eff - ONE;
    assign w_last     = r_mod - ONE;
    assign w_in_ok    = w_in_ext < w_mod_eff;
    assign w_shrink   = w_mod_ok && !i_load && (w_cnt_ext >= w_mod_eff);

    always_comb begin
        w_next_cnt  = r_count;
        w_next_wrap = 1'b0;
        if (i_load) begin
            w_next_cnt = w_in_ok ? i_count_in : w_last_eff[WIDTH-1:0];
        end else if (w_shrink) begin
            w_next_cnt = {WIDTH{1'b0}};
        end else if (i_enable) begin
            if (i_mode) begin
                if (w_cnt_ext == w_last_eff) begin
                    w_next_cnt  = {WIDTH{1'b0}};
                    w_next_wrap = 1'b1;
                end else begin
                    w_next_cnt = r_count + 1'b1;
                end
            end else begin
                if (r_count == {WIDTH{1'b0}}) begin
                    w_next_cnt  = w_last_eff[WIDTH-1:0];
                    w_next_wrap = 1'b1;
                end else begin
                    w_next_cnt = r_count - 1'b1;
                end
            end
        end
    end

    // One pulse covers a bad modulus, a clamped load, or both.
    assign w_next_err = (i_mod_load && !w_mod_ok) || (i_load && !w_in_ok);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= {WIDTH{1'b0}};
            r_mod   <= MOD_RST;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_next_cnt;
            r_mod   <= w_mod_eff;
            r_wrap  <= w_next_wrap;
            r_err   <= w_next_err;
        end
    end

    assign o_count_out = r_count;
    assign o_modulus   = r_mod;
    assign o_wrap      = r_wrap;
    assign o_load_err  = r_err;
    assign o_tc        = i_enable &&
                         ((i_mode && (w_cnt_ext == w_last)) ||
                          (!i_mode && (r_count == {WIDTH{1'b0}})));

endmodule
